// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared widths, opcode encoding and decode helper for the mcpu CPU.
// No ports; imported by the interface, sub-modules and the top.
package mcpu_pkg;

  localparam int unsigned MCPU_WORD  = 16;  // data / instruction width
  localparam int unsigned MCPU_OPND  = 4;   // opcode and register-index field width
  localparam int unsigned MCPU_ADDR  = 8;   // RAM address width
  localparam int unsigned MCPU_NREGS = 16;  // register count

  typedef enum logic [MCPU_OPND-1:0] {
    OpNop        = 4'd0,
    OpAdd        = 4'd1,
    OpSub        = 4'd2,
    OpAnd        = 4'd3,
    OpOr         = 4'd4,
    OpXor        = 4'd5,
    OpNot        = 4'd6,
    OpLsl        = 4'd7,
    OpLsr        = 4'd8,
    OpMov        = 4'd9,
    OpShortToReg = 4'd10,
    OpLoad       = 4'd11,
    OpStore      = 4'd12,
    OpBnz        = 4'd13
  } opcode_e;

  // ALU ops, immediate and load all write the destination register.
  function automatic logic op_writes_reg(logic [MCPU_OPND-1:0] op);
    return (op >= 4'd1) && (op <= 4'd11);
  endfunction

endpackage

// File: rtl/mcpu_if.sv
// mcpu_if: single-port RAM bus between the CPU core and its unified memory.
//   addr  - word address (fetch, load and store share it)
//   wdata - store data
//   we    - write enable, sampled on the rising clock edge
//   rdata - combinational read data at addr
interface mcpu_if
  import mcpu_pkg::*;
();
  logic [MCPU_ADDR-1:0] addr;
  logic [MCPU_WORD-1:0] wdata;
  logic                 we;
  logic [MCPU_WORD-1:0] rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/mcpu_ram.sv
// mcpu_ram: 256-word unified instruction/data RAM.
//   i_clk  - write clock
//   io_bus - slave side of mcpu_if (combinational read, synchronous write)
// Contents are never reset so preloaded programs survive a CPU reset.
module mcpu_ram
  import mcpu_pkg::*;
(
  input logic   i_clk,
  mcpu_if.slave io_bus
);

  logic [MCPU_WORD-1:0] mem [0:(1<<MCPU_ADDR)-1];

  always_ff @(posedge i_clk) begin
    if (io_bus.we) begin
      mem[io_bus.addr] <= io_bus.wdata;
    end
  end

  assign io_bus.rdata = mem[io_bus.addr];

endmodule

// File: rtl/mcpu_regfile.sv
// mcpu_regfile: register file, two combinational read ports, one synchronous write port.
//   i_clk            - write clock
//   i_we/i_waddr/i_wdata - write port
//   i_raddr1/o_rdata1, i_raddr2/o_rdata2 - read ports
// Contents are never reset.
module mcpu_regfile
  import mcpu_pkg::*;
#(
  parameter int unsigned REGS = MCPU_NREGS
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [MCPU_OPND-1:0] i_waddr,
  input  logic [MCPU_WORD-1:0] i_wdata,
  input  logic [MCPU_OPND-1:0] i_raddr1,
  input  logic [MCPU_OPND-1:0] i_raddr2,
  output logic [MCPU_WORD-1:0] o_rdata1,
  output logic [MCPU_WORD-1:0] o_rdata2
);

  logic [MCPU_WORD-1:0] R [0:REGS-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      R[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = R[i_raddr1];
  assign o_rdata2 = R[i_raddr2];

endmodule

// File: rtl/mcpu.sv
// mcpu: multi-cycle 16-bit load/store CPU (FETCH -> EXECUTE -> WRITEBACK).
//   clk   - rising-edge clock
//   reset - synchronous active-high; clears PC, IR, result and FSM only
// Sub-instances: raminst (mcpu_ram, array mem), regfileinst (mcpu_regfile, array R).
module mcpu
  import mcpu_pkg::*;
(
  input logic clk,
  input logic reset
);

  localparam int unsigned WORD_SIZE    = MCPU_WORD;
  localparam int unsigned OPERAND_SIZE = MCPU_OPND;
  localparam int unsigned ADDR_SIZE    = MCPU_ADDR;
  localparam int unsigned REGS         = MCPU_NREGS;

  localparam logic [OPERAND_SIZE-1:0] OP_NOP          = OpNop;
  localparam logic [OPERAND_SIZE-1:0] OP_ADD          = OpAdd;
  localparam logic [OPERAND_SIZE-1:0] OP_SUB          = OpSub;
  localparam logic [OPERAND_SIZE-1:0] OP_AND          = OpAnd;
  localparam logic [OPERAND_SIZE-1:0] OP_OR           = OpOr;
  localparam logic [OPERAND_SIZE-1:0] OP_XOR          = OpXor;
  localparam logic [OPERAND_SIZE-1:0] OP_NOT          = OpNot;
  localparam logic [OPERAND_SIZE-1:0] OP_LSL          = OpLsl;
  localparam logic [OPERAND_SIZE-1:0] OP_LSR          = OpLsr;
  localparam logic [OPERAND_SIZE-1:0] OP_MOV          = OpMov;
  localparam logic [OPERAND_SIZE-1:0] OP_SHORT_TO_REG = OpShortToReg;
  localparam logic [OPERAND_SIZE-1:0] OP_LOAD         = OpLoad;
  localparam logic [OPERAND_SIZE-1:0] OP_STORE        = OpStore;
  localparam logic [OPERAND_SIZE-1:0] OP_BNZ          = OpBnz;

  localparam logic [1:0] S_FETCH     = 2'd0;
  localparam logic [1:0] S_EXECUTE   = 2'd1;
  localparam logic [1:0] S_WRITEBACK = 2'd2;

  logic [1:0]              r_state;
  logic [ADDR_SIZE-1:0]    r_pc;
  logic [WORD_SIZE-1:0]    r_ir;
  logic [WORD_SIZE-1:0]    r_result;

  logic [OPERAND_SIZE-1:0] w_op, w_dest, w_src1, w_src2, w_raddr2;
  logic [WORD_SIZE-1:0]    w_a, w_b, w_alu;
  logic                    w_rf_we;

  assign w_op   = r_ir[15:12];
  assign w_dest = r_ir[11:8];
  assign w_src1 = r_ir[7:4];
  assign w_src2 = r_ir[3:0];

  // STORE and BNZ need R[dest] instead of R[src2]; neither uses src2 as a register.
  assign w_raddr2 = (w_op == OP_STORE || w_op == OP_BNZ) ? w_dest : w_src2;

  // Writes are suppressed on any edge where reset is high.
  assign w_rf_we = (r_state == S_WRITEBACK) && op_writes_reg(w_op) && !reset;

  mcpu_if ram_bus ();

  mcpu_ram raminst (
    .i_clk  (clk),
    .io_bus (ram_bus)
  );

  mcpu_regfile #(
    .REGS (REGS)
  ) regfileinst (
    .i_clk    (clk),
    .i_we     (w_rf_we),
    .i_waddr  (w_dest),
    .i_wdata  (r_result),
    .i_raddr1 (w_src1),
    .i_raddr2 (w_raddr2),
    .o_rdata1 (w_a),
    .o_rdata2 (w_b)
  );

  // One RAM port: PC during FETCH, R[src1] for load (EXECUTE) and store (WRITEBACK).
  always_comb begin
    ram_bus.addr  = (r_state == S_FETCH) ? r_pc : w_a[ADDR_SIZE-1:0];
    ram_bus.wdata = w_b;
    ram_bus.we    = (r_state == S_WRITEBACK) && (w_op == OP_STORE) && !reset;
  end

  always_comb begin
    w_alu = '0;
    unique case (w_op)
      OP_ADD:          w_alu = w_a + w_b;
      OP_SUB:          w_alu = w_a - w_b;
      OP_AND:          w_alu = w_a & w_b;
      OP_OR:           w_alu = w_a | w_b;
      OP_XOR:          w_alu = w_a ^ w_b;
      OP_NOT:          w_alu = ~w_a;
      OP_LSL:          w_alu = (|w_b[WORD_SIZE-1:4]) ? '0 : (w_a << w_b[3:0]);
      OP_LSR:          w_alu = (|w_b[WORD_SIZE-1:4]) ? '0 : (w_a >> w_b[3:0]);
      OP_MOV:          w_alu = w_a;
      OP_SHORT_TO_REG: w_alu = {{8{r_ir[7]}}, r_ir[7:0]};
      OP_LOAD:         w_alu = ram_bus.rdata;
      OP_NOP:          w_alu = '0;
      default:         w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_pc     <= '0;
      r_ir     <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_ir    <= ram_bus.rdata;
          r_state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          r_result <= w_alu;
          r_state  <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          if (w_op == OP_BNZ && w_b != '0) r_pc <= r_ir[7:0];
          else                             r_pc <= r_pc + 8'd1;
          r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu.sv
module tb_mcpu;
  import mcpu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mismatched = 0;

  logic [15:0] m_mem [256];
  logic [15:0] m_r [16];
  logic [7:0]  m_pc;

  mcpu dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset across an edge, then zero RAM and registers.
  task automatic start();
    reset = 1'b1;
    cycles(1);
    for (int i = 0; i < 256; i++) dut.raminst.mem[i] = 16'h0;
    for (int i = 0; i < 16; i++) dut.regfileinst.R[i] = 16'h0;
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] d,
                                      input logic [3:0] a, input logic [3:0] b);
    return {op, d, a, b};
  endfunction

  // ISA-level reference: executes one whole instruction.
  task automatic model_step();
    logic [15:0] ir, a, b;
    logic [3:0]  op, d;
    ir = m_mem[m_pc];
    op = ir[15:12];
    d  = ir[11:8];
    a  = m_r[ir[7:4]];
    b  = m_r[ir[3:0]];
    case (op)
      4'd1:  m_r[d] = a + b;
      4'd2:  m_r[d] = a - b;
      4'd3:  m_r[d] = a & b;
      4'd4:  m_r[d] = a | b;
      4'd5:  m_r[d] = a ^ b;
      4'd6:  m_r[d] = ~a;
      4'd7:  m_r[d] = a << b;
      4'd8:  m_r[d] = a >> b;
      4'd9:  m_r[d] = a;
      4'd10: m_r[d] = {{8{ir[7]}}, ir[7:0]};
      4'd11: m_r[d] = m_mem[a[7:0]];
      4'd12: m_mem[a[7:0]] = m_r[d];
      default: ;
    endcase
    if (op == 4'd13 && m_r[d] != 16'h0) m_pc = ir[7:0];
    else                                m_pc = m_pc + 8'd1;
  endtask

  initial begin
    logic [15:0] v;

    // Reset preservation and mid-instruction abort.
    start();
    dut.regfileinst.R[3] = 16'hBEEF;
    dut.raminst.mem[5]   = 16'h1234;
    dut.raminst.mem[0]   = ins(OpShortToReg, 4'd3, 4'd1, 4'd1);
    cycles(3);
    check("rst_r3", dut.regfileinst.R[3], 16'hBEEF);
    check("rst_mem5", dut.raminst.mem[5], 16'h1234);
    check("rst_pc", {8'h0, dut.r_pc}, 16'h0);
    check("rst_ir", dut.r_ir, 16'h0);
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
    cycles(1);
    check("abort_r3", dut.regfileinst.R[3], 16'hBEEF);
    check("abort_pc", {8'h0, dut.r_pc}, 16'h0);
    reset = 1'b0;
    cycles(3);
    check("restart_r3", dut.regfileinst.R[3], 16'h0011);
    check("restart_pc", {8'h0, dut.r_pc}, 16'h1);

    // Shift pair, then run NOPs until PC wraps to 0.
    start();
    dut.regfileinst.R[0] = 16'd4488;
    dut.regfileinst.R[1] = 16'd4488;
    dut.regfileinst.R[2] = 16'd2;
    dut.raminst.mem[0] = ins(OpLsl, 4'd0, 4'd0, 4'd2);
    dut.raminst.mem[1] = ins(OpLsr, 4'd1, 4'd1, 4'd2);
    reset = 1'b0;
    cycles(3);
    check("lsl_r0", dut.regfileinst.R[0], 16'd17952);
    cycles(3);
    check("lsr_r1", dut.regfileinst.R[1], 16'd1122);
    check("shift_r2", dut.regfileinst.R[2], 16'd2);
    cycles(254 * 3);
    check("wrap_pc", {8'h0, dut.r_pc}, 16'h0);
    check("wrap_r0", dut.regfileinst.R[0], 16'd17952);
    check("wrap_r1", dut.regfileinst.R[1], 16'd1122);

    // Arithmetic wrap-around.
    start();
    dut.regfileinst.R[1] = 16'hFFFF;
    dut.regfileinst.R[2] = 16'h0001;
    dut.raminst.mem[0] = ins(OpAdd, 4'd3, 4'd1, 4'd2);
    dut.raminst.mem[1] = ins(OpSub, 4'd4, 4'd3, 4'd2);
    reset = 1'b0;
    cycles(6);
    check("add_r3", dut.regfileinst.R[3], 16'h0000);
    check("sub_r4", dut.regfileinst.R[4], 16'hFFFF);

    // Immediate, store, load.
    start();
    dut.raminst.mem[0] = ins(OpShortToReg, 4'd5, 4'hF, 4'h0);
    dut.raminst.mem[1] = ins(OpShortToReg, 4'd6, 4'h4, 4'h0);
    dut.raminst.mem[2] = ins(OpStore, 4'd5, 4'd6, 4'd0);
    dut.raminst.mem[3] = ins(OpLoad, 4'd7, 4'd6, 4'd0);
    reset = 1'b0;
    cycles(12);
    check("imm_r5", dut.regfileinst.R[5], 16'hFFF0);
    check("imm_r6", dut.regfileinst.R[6], 16'h0040);
    check("store_mem64", dut.raminst.mem[64], 16'hFFF0);
    check("load_r7", dut.regfileinst.R[7], 16'hFFF0);

    // Branch loop.
    start();
    dut.regfileinst.R[1] = 16'd3;
    dut.regfileinst.R[2] = 16'd1;
    dut.raminst.mem[0] = ins(OpSub, 4'd1, 4'd1, 4'd2);
    dut.raminst.mem[1] = ins(OpBnz, 4'd1, 4'd0, 4'd0);
    reset = 1'b0;
    cycles(6);
    check("bnz_taken_pc", {8'h0, dut.r_pc}, 16'h0);
    check("bnz_iter1_r1", dut.regfileinst.R[1], 16'd2);
    cycles(12);
    check("loop_r1", dut.regfileinst.R[1], 16'd0);
    check("loop_pc", {8'h0, dut.r_pc}, 16'h2);

    // Shift bounds.
    start();
    dut.regfileinst.R[1] = 16'h1234;
    dut.regfileinst.R[2] = 16'd16;
    dut.regfileinst.R[4] = 16'h8000;
    dut.regfileinst.R[5] = 16'd15;
    dut.raminst.mem[0] = ins(OpLsl, 4'd3, 4'd1, 4'd2);
    dut.raminst.mem[1] = ins(OpLsr, 4'd6, 4'd4, 4'd5);
    reset = 1'b0;
    cycles(6);
    check("lsl16_r3", dut.regfileinst.R[3], 16'h0000);
    check("lsr15_r6", dut.regfileinst.R[6], 16'h0001);

    // Random programs against the ISA model.
    for (int round = 0; round < 4; round++) begin
      start();
      for (int i = 0; i < 256; i++) begin
        v = 16'($urandom);
        m_mem[i] = v;
        dut.raminst.mem[i] = v;
      end
      for (int i = 0; i < 16; i++) begin
        v = (i < 4) ? 16'($urandom_range(0, 20)) : 16'($urandom);
        m_r[i] = v;
        dut.regfileinst.R[i] = v;
      end
      m_pc = 8'h0;
      reset = 1'b0;
      for (int k = 0; k < 60; k++) model_step();
      cycles(60 * 3);
      check($sformatf("rnd%0d_pc", round), {8'h0, dut.r_pc}, {8'h0, m_pc});
      for (int i = 0; i < 16; i++)
        check($sformatf("rnd%0d_R%0d", round, i), dut.regfileinst.R[i], m_r[i]);
      for (int i = 0; i < 256; i++)
        check($sformatf("rnd%0d_mem%0d", round, i), dut.raminst.mem[i], m_mem[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
